// File: rtl/fc_apb_host_if.sv
// Request/response channel plus APB3 bus seen by the FC accelerator host initiator.
interface fc_apb_host_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
);
   // Request channel
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic                 req_poll;
   logic [AddrWidth-1:0] req_addr;
   logic [DataWidth-1:0] req_wdata;
   // Response channel
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DataWidth-1:0] rsp_rdata;
   logic                 rsp_err;
   logic                 rsp_timeout;
   logic [15:0]          rsp_attempts;
   // APB3
   logic [AddrWidth-1:0] paddr;
   logic                 psel;
   logic                 penable;
   logic                 pwrite;
   logic [DataWidth-1:0] pwdata;
   logic [DataWidth-1:0] prdata;
   logic                 pready;
   logic                 pslverr;

   // Host (initiator) side
   modport master (
      input  req_valid, req_write, req_poll, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_attempts,
      input  rsp_ready,
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   // Requester / APB completer side
   modport slave (
      output req_valid, req_write, req_poll, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_attempts,
      output rsp_ready,
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/fc_apb_host.sv
// APB3 initiator: one request in, one APB transfer (or a polled series of reads), one response out.
module fc_apb_host #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned PollMax   = 16,
   parameter int unsigned PollGap   = 2
) (
   input logic           clk_i,
   input logic           rst_i,
   fc_apb_host_if.master bus_io
);

   typedef enum logic [2:0] {StIdle, StSetup, StAccess, StGap, StResp} state_e;

   localparam logic [15:0] PollMaxC = 16'(PollMax);
   // GAP lasts PollGap cycles: load PollGap-1 and leave when the counter is 0.
   localparam logic [15:0] GapLoad  = (PollGap == 0) ? 16'd0 : 16'(PollGap - 1);

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] paddr_q, paddr_d;
   logic [DataWidth-1:0] pwdata_q, pwdata_d;
   logic                 pwrite_q, pwrite_d;
   logic                 psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic [DataWidth-1:0] mask_q, mask_d;
   logic                 poll_q, poll_d;
   logic [15:0]          attempts_q, attempts_d;
   logic [15:0]          gap_q, gap_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 rsp_timeout_q, rsp_timeout_d;
   logic [15:0]          rsp_attempts_q, rsp_attempts_d;

   logic req_ready;
   logic accept;
   logic xfer_done;
   logic hit;
   logic last;
   logic finish;

   assign req_ready = (state_q == StIdle) && !rst_i;
   assign accept    = bus_io.req_valid && req_ready;
   assign xfer_done = (state_q == StAccess) && bus_io.pready;
   assign hit       = |(bus_io.prdata & mask_q);
   assign last      = (attempts_q + 16'd1) == PollMaxC;
   assign finish    = pwrite_q || bus_io.pslverr || !poll_q || hit || last;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StSetup;
         StSetup:  state_d = StAccess;
         StAccess: begin
            if (bus_io.pready) begin
               if (finish)            state_d = StResp;
               else if (PollGap == 0) state_d = StSetup;
               else                   state_d = StGap;
            end
         end
         StGap:    if (gap_q == 16'd0) state_d = StSetup;
         StResp:   if (bus_io.rsp_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output and datapath next values; outputs are registered from the next state
   always_comb begin
      paddr_d        = paddr_q;
      pwdata_d       = pwdata_q;
      pwrite_d       = pwrite_q;
      mask_d         = mask_q;
      poll_d         = poll_q;
      attempts_d     = attempts_q;
      gap_d          = gap_q;
      rsp_rdata_d    = rsp_rdata_q;
      rsp_err_d      = rsp_err_q;
      rsp_timeout_d  = rsp_timeout_q;
      rsp_attempts_d = rsp_attempts_q;

      psel_d      = (state_d == StSetup) || (state_d == StAccess);
      penable_d   = (state_d == StAccess);
      rsp_valid_d = (state_d == StResp);

      if (accept) begin
         paddr_d    = bus_io.req_addr;
         pwrite_d   = bus_io.req_write;
         pwdata_d   = bus_io.req_write ? bus_io.req_wdata : '0;
         mask_d     = bus_io.req_wdata;
         poll_d     = bus_io.req_poll && !bus_io.req_write;
         attempts_d = 16'd0;
      end

      if (xfer_done) begin
         attempts_d = attempts_q + 16'd1;
         if (finish) begin
            rsp_rdata_d    = pwrite_q ? '0 : bus_io.prdata;
            rsp_err_d      = bus_io.pslverr;
            // Timeout only when the poll ran out without a hit or an error
            rsp_timeout_d  = poll_q && !bus_io.pslverr && !hit && last;
            rsp_attempts_d = attempts_q + 16'd1;
         end else begin
            gap_d = GapLoad;
         end
      end

      if ((state_q == StGap) && (gap_q != 16'd0)) begin
         gap_d = gap_q - 16'd1;
      end
   end

   // Output and datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         paddr_q        <= '0;
         pwdata_q       <= '0;
         pwrite_q       <= 1'b0;
         psel_q         <= 1'b0;
         penable_q      <= 1'b0;
         mask_q         <= '0;
         poll_q         <= 1'b0;
         attempts_q     <= 16'd0;
         gap_q          <= 16'd0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         rsp_err_q      <= 1'b0;
         rsp_timeout_q  <= 1'b0;
         rsp_attempts_q <= 16'd0;
      end else begin
         paddr_q        <= paddr_d;
         pwdata_q       <= pwdata_d;
         pwrite_q       <= pwrite_d;
         psel_q         <= psel_d;
         penable_q      <= penable_d;
         mask_q         <= mask_d;
         poll_q         <= poll_d;
         attempts_q     <= attempts_d;
         gap_q          <= gap_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_err_q      <= rsp_err_d;
         rsp_timeout_q  <= rsp_timeout_d;
         rsp_attempts_q <= rsp_attempts_d;
      end
   end

   assign bus_io.req_ready    = req_ready;
   assign bus_io.paddr        = paddr_q;
   assign bus_io.pwdata       = pwdata_q;
   assign bus_io.pwrite       = pwrite_q;
   assign bus_io.psel         = psel_q;
   assign bus_io.penable      = penable_q;
   assign bus_io.rsp_valid    = rsp_valid_q;
   assign bus_io.rsp_rdata    = rsp_rdata_q;
   assign bus_io.rsp_err      = rsp_err_q;
   assign bus_io.rsp_timeout  = rsp_timeout_q;
   assign bus_io.rsp_attempts = rsp_attempts_q;

endmodule

// File: tb/tb_fc_apb_host.sv
// Directed bench for fc_apb_host: table of single transfers plus hand-written poll/reset sequences.
module tb_fc_apb_host;
   localparam int unsigned PollMax = 16;
   localparam int unsigned PollGap = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fc_apb_host_if #(.AddrWidth(32), .DataWidth(32)) bus ();

   fc_apb_host #(
      .AddrWidth(32),
      .DataWidth(32),
      .PollMax  (PollMax),
      .PollGap  (PollGap)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus_io(bus)
   );

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endfunction

   // APB completer model: cfg_wait wait states per transfer, data from rd_seq, error on attempt err_at
   int          cfg_wait  = 0;
   int          err_at    = 0;
   int          wait_cnt  = 0;
   int          xfer_cnt  = 0;
   int          xfer_base = 0;
   int          idx;
   logic [31:0] rd_seq [32];

   assign idx = xfer_cnt - xfer_base;

   always_comb begin
      bus.pready  = bus.psel && bus.penable && (wait_cnt >= cfg_wait);
      bus.prdata  = (idx >= 0 && idx < 32) ? rd_seq[idx[4:0]] : 32'h0;
      bus.pslverr = bus.pready && ((idx + 1) == err_at);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= 0;
      end else if (bus.psel && bus.penable) begin
         if (bus.pready) begin
            wait_cnt <= 0;
            xfer_cnt <= xfer_cnt + 1;
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end else begin
         wait_cnt <= 0;
      end
   end

   // Protocol monitor: counts APB violations and records PSEL-low run before each transfer
   logic [31:0] exp_addr   = '0;
   logic [31:0] exp_pwdata = '0;
   logic        exp_pwrite = 1'b0;
   int          apb_viol   = 0;
   int          low_run    = 0;
   int          gaps [32];
   logic        prev_psel  = 1'b0;
   logic        prev_pen   = 1'b0;
   logic        bad;

   assign bad = bus.psel ? ((bus.paddr !== exp_addr) || (bus.pwdata !== exp_pwdata) ||
                            (bus.pwrite !== exp_pwrite) || (bus.penable && !prev_psel) ||
                            (!bus.penable && prev_psel && !prev_pen))
                         : (bus.penable !== 1'b0);

   always @(negedge clk) begin
      if (rst) begin
         prev_psel <= 1'b0;
         prev_pen  <= 1'b0;
         low_run   <= 0;
      end else begin
         if (bad) apb_viol <= apb_viol + 1;
         if (bus.psel && !bus.penable) begin
            if (idx >= 0 && idx < 32) gaps[idx[4:0]] <= low_run;
            low_run <= 0;
         end else if (!bus.psel) begin
            low_run <= low_run + 1;
         end
         prev_psel <= bus.psel;
         prev_pen  <= bus.penable;
      end
   end

   task automatic run_req(input string nm, input bit w, input bit poll, input logic [31:0] addr,
                          input logic [31:0] wdata, input int wt, input int ea, input int bp,
                          input logic [31:0] e_rdata, input bit e_err, input bit e_tout,
                          input int e_att, input int e_lat);
      int acc;
      int n;
      int vb;
      cfg_wait   = wt;
      err_at     = ea;
      xfer_base  = xfer_cnt;
      vb         = apb_viol;
      exp_addr   = addr;
      exp_pwrite = w;
      exp_pwdata = w ? wdata : 32'h0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_poll  = poll;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         check({nm, "_accept"}, 32'(bus.req_ready), 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      // Garbage on the request channel must be ignored after the accept edge
      bus.req_valid = 1'b0;
      bus.req_write = ~w;
      bus.req_poll  = ~poll;
      bus.req_addr  = 32'hffff_fff0;
      bus.req_wdata = ~wdata;
      n = 0;
      while (!bus.rsp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rsp_valid) begin
         check({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
         return;
      end
      check({nm, "_latency"}, 32'(cyc - acc + 1), 32'(e_lat));
      check({nm, "_rdata"}, bus.rsp_rdata, e_rdata);
      check({nm, "_err"}, 32'(bus.rsp_err), 32'(e_err));
      check({nm, "_timeout"}, 32'(bus.rsp_timeout), 32'(e_tout));
      check({nm, "_attempts"}, 32'(bus.rsp_attempts), 32'(e_att));
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check({nm, "_bp_valid"}, 32'(bus.rsp_valid), 32'd1);
         check({nm, "_bp_rdata"}, bus.rsp_rdata, e_rdata);
         check({nm, "_bp_attempts"}, 32'(bus.rsp_attempts), 32'(e_att));
         check({nm, "_bp_req_ready"}, 32'(bus.req_ready), 32'd0);
         check({nm, "_bp_psel"}, 32'(bus.psel), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({nm, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
      check({nm, "_req_ready_next"}, 32'(bus.req_ready), 32'd1);
      check({nm, "_apb_protocol"}, 32'(apb_viol - vb), 32'd0);
   endtask

   typedef struct {
      bit          w;
      bit          poll;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prd;
      int          wt;
      int          ea;
      int          bp;
      logic [31:0] e_rdata;
      bit          e_err;
      int          e_att;
      int          e_lat;
   } vec_t;

   vec_t vecs [6];

   initial begin
      // w poll addr wdata prdata waits err_at backpressure | rdata err attempts latency
      vecs[0] = '{1'b1, 1'b0, 32'h4,  32'h3,         32'h0,         0, 0, 0,
                  32'h0,         1'b0, 1, 3};
      vecs[1] = '{1'b0, 1'b0, 32'h8,  32'h0,         32'h7,         3, 0, 0,
                  32'h7,         1'b0, 1, 6};
      vecs[2] = '{1'b1, 1'b0, 32'h10, 32'hdead_beef, 32'h0,         1, 1, 0,
                  32'h0,         1'b1, 1, 4};
      vecs[3] = '{1'b0, 1'b0, 32'hc,  32'h0,         32'ha5a5_0001, 0, 1, 5,
                  32'ha5a5_0001, 1'b1, 1, 3};
      vecs[4] = '{1'b0, 1'b0, 32'h14, 32'hffff_ffff, 32'h0,         0, 0, 0,
                  32'h0,         1'b0, 1, 3};
      vecs[5] = '{1'b1, 1'b1, 32'h18, 32'h55,        32'h1234,      0, 0, 0,
                  32'h0,         1'b0, 1, 3};

      for (int i = 0; i < 32; i++) rd_seq[i] = 32'h0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_poll  = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      rst = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_psel", 32'(bus.psel), 32'd0);
      check("rst_penable", 32'(bus.penable), 32'd0);
      check("rst_pwrite", 32'(bus.pwrite), 32'd0);
      check("rst_paddr", bus.paddr, 32'h0);
      check("rst_pwdata", bus.pwdata, 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("rst_rsp_attempts", 32'(bus.rsp_attempts), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

      // Single-transfer table
      for (int i = 0; i < 6; i++) begin
         rd_seq[0] = vecs[i].prd;
         run_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].poll, vecs[i].addr, vecs[i].wdata,
                 vecs[i].wt, vecs[i].ea, vecs[i].bp, vecs[i].e_rdata, vecs[i].e_err, 1'b0,
                 vecs[i].e_att, vecs[i].e_lat);
      end

      // Poll success on 3rd read: 3 + 2*(2+PollGap) cycles
      for (int i = 0; i < 32; i++) rd_seq[i] = 32'h0;
      rd_seq[2] = 32'h1;
      run_req("poll_ok", 1'b0, 1'b1, 32'h30, 32'h1, 0, 0, 0, 32'h1, 1'b0, 1'b0, 3, 11);
      check("poll_ok_gap1", 32'(gaps[1]), 32'(PollGap));
      check("poll_ok_gap2", 32'(gaps[2]), 32'(PollGap));

      // Poll with wait states: each transfer adds one cycle
      run_req("poll_wait", 1'b0, 1'b1, 32'h34, 32'h1, 1, 0, 0, 32'h1, 1'b0, 1'b0, 3, 14);

      // Poll timeout after PollMax attempts
      rd_seq[2] = 32'h0;
      run_req("poll_tout", 1'b0, 1'b1, 32'h38, 32'h1, 0, 0, 0, 32'h0, 1'b0, 1'b1, 16, 63);

      // Hit on the very last attempt is not a timeout
      rd_seq[15] = 32'h1;
      run_req("poll_last_hit", 1'b0, 1'b1, 32'h3c, 32'h1, 0, 0, 0, 32'h1, 1'b0, 1'b0, 16, 63);

      // Zero mask never matches
      for (int i = 0; i < 32; i++) rd_seq[i] = 32'hffff_ffff;
      run_req("poll_mask0", 1'b0, 1'b1, 32'h40, 32'h0, 0, 0, 0, 32'hffff_ffff, 1'b0, 1'b1,
              16, 63);

      // Slave error on the 2nd attempt ends the poll
      for (int i = 0; i < 32; i++) rd_seq[i] = 32'h0;
      rd_seq[1] = 32'h100;
      run_req("poll_err", 1'b0, 1'b1, 32'h44, 32'h1, 0, 2, 0, 32'h100, 1'b1, 1'b0, 2, 7);

      // Reset while in ACCESS with the completer stalling
      cfg_wait   = 10;
      err_at     = 0;
      xfer_base  = xfer_cnt;
      exp_addr   = 32'h20;
      exp_pwrite = 1'b0;
      exp_pwdata = 32'h0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_poll  = 1'b0;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'h0;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int n = 0; n < 10 && !bus.penable; n++) @(negedge clk);
      check("mid_rst_in_access", 32'(bus.penable), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_psel", 32'(bus.psel), 32'd0);
      check("mid_rst_penable", 32'(bus.penable), 32'd0);
      check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_release_ready", 32'(bus.req_ready), 32'd1);
      repeat (3) @(negedge clk);
      check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_no_psel", 32'(bus.psel), 32'd0);
      rd_seq[0] = 32'h0000_0042;
      run_req("after_rst", 1'b0, 1'b0, 32'h24, 32'h0, 0, 0, 0, 32'h42, 1'b0, 1'b0, 1, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "watchdog expired");
   end

endmodule
